timer_sched: RTL
================

// Module: timer_sched
// PURPOSE
//  Shares one CW-bit up-counter timer between NREQ requesters. A round-robin arbiter grants it to one
//  requester at a time, loads that requester's limit and mode, runs the count and returns a done pulse.
//  Sits between software-visible channel registers and the single timer datapath.
// PARAMETERS
//  NREQ  4  number of requesters (2..8)
//  CW    8  counter/limit width in bits
// PORTS
//  clk        in   1          clock, all logic on posedge
//  rst        in   1          synchronous, active-high reset
//  req        in   NREQ       level request per requester; held high until its done pulse
//  req_limit  in   NREQ*CW    terminal count per requester, slice i = [i*CW +: CW]
//  req_per    in   NREQ       1 = periodic, 0 = one-shot; sampled in LOAD
//  grant      out  NREQ       one-hot owner of the timer, all-zero when idle
//  done       out  NREQ       one-cycle pulse to the owner at terminal count
//  busy       out  1          high in any state other than IDLE
//  count      out  CW         live counter value, 0 when idle
//  aborted    out  NREQ       one-cycle abort pulse; present only with TIMER_SCHED_ABORT_EN
// BEHAVIOUR
//  - Reset: state IDLE; grant, done, aborted, count = 0; busy = 0; round-robin pointer = 0.
//    Reset applied mid-operation discards the transaction with no done pulse.
//  - All outputs are registered. State machine IDLE -> LOAD -> RUN -> DONE:
//    IDLE: if any req is high, pick the first set bit at or after ptr, wrapping. Set grant and move to LOAD.
//    LOAD: count <= 0; latch limit and per for the granted index; move to RUN.
//    RUN:  if count == limit, move to DONE; otherwise count <= count + 1. count never wraps past limit.
//    DONE: done[g] = 1 for exactly this cycle.
//      If per = 1 and req[g] = 1: count <= 0, return to RUN, keep grant.
//      Otherwise: clear grant, set ptr = g + 1 (mod NREQ), count <= 0, return to IDLE.
//  - Latency: req rises in cycle T (IDLE) -> grant in T+1 -> RUN from T+2 -> done in T+3+limit.
//    limit = 0 gives done in T+3.
//  - Periodic period = limit + 2 cycles (RUN 0..limit, then DONE).
//  - A requester must drop req in the cycle after done; a req still high is re-arbitrated fairly.
//  - Simultaneous requests: the first set bit at or after ptr wins. No requester waits more than NREQ-1 grants.
//  - req_limit/req_per changes while granted are ignored until the next LOAD.
//  - An idle cycle is always inserted between consecutive grants.
// CONFIGURATION
//  TIMER_SCHED_ABORT_EN defined:
//    - req[g] low during LOAD or RUN -> next cycle IDLE, aborted[g] pulses 1 cycle, no done,
//      ptr advances as on completion.
//    - req[g] low during DONE is a normal completion.
//  Not defined: the aborted port is omitted; req drops during LOAD/RUN are ignored and the count runs to done.
// STRUCTURE
//  timer_sched_pkg: state enum (IDLE, LOAD, RUN, DONE), localparam widths, log2 helper function.
//  Sub-module rr_arbiter (NREQ): combinational round-robin pick, inputs req and ptr,
//  outputs one-hot pick and valid. timer_sched holds the FSM, counter and pointer.
// TESTING
//  1. Reset, then req=0001, limit0=5, one-shot -> grant=0001 at T+1, done[0] at T+8, grant=0 at T+9.
//  2. req=1111, all limits 0 -> grants in order 0,1,2,3,0; each done 3 cycles after its grant cycle minus 1;
//     one idle cycle between grants.
//  3. req2 periodic, limit=3, held 3 periods -> done[2] every 5 cycles; release after req2 drops.
//  4. limit=8'hFF one-shot -> count reaches 255, done in T+258, count never wraps to 0 mid-run.
//  5. rst asserted in RUN with count=4 -> next cycle grant=0, count=0, busy=0, no done; ptr=0.
//  6. ABORT_EN on: drop req1 when count=2 -> aborted[1] pulses, no done[1], req3 is granted next.
//     ABORT_EN off: the same stimulus completes with done[1].

Source files
------------

// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: shared FSM state type, default sizes and a log2 helper for the timer scheduler.
package timer_sched_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_CW = 8;
  function automatic int lg2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational pick of the first set request at or after ptr, wrapping.
module rr_arbiter import timer_sched_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int PW = lg2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic            valid
);
  always_comb begin
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) pick = NREQ'(1) << ((int'(ptr) + k) % NREQ);
  end
  assign valid = |req;
endmodule

// File: rtl/timer_sched.sv
// timer_sched: one CW-bit timer shared round-robin between NREQ requesters.
// Define TIMER_SCHED_ABORT_EN to add the aborted port and release on an early req drop.
module timer_sched import timer_sched_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int CW = DEF_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*CW-1:0] req_limit,
  input  logic [NREQ-1:0]  req_per,
  output logic [NREQ-1:0]  grant,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic [CW-1:0]    count
`ifdef TIMER_SCHED_ABORT_EN
  ,
  output logic [NREQ-1:0]  aborted
`endif
);
  localparam int PW = lg2(NREQ);
  state_t state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d, done_q, done_d, pick, ab_d;
  logic [CW-1:0] count_q, count_d, lim_q, lim_d;
  logic [PW-1:0] ptr_q, ptr_d, idx_q, idx_d, pick_idx, nxt;
  logic per_q, per_d, valid;
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (.req(req), .ptr(ptr_q), .pick(pick), .valid(valid));
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) if (pick[i]) pick_idx = PW'(i);
  end
  assign nxt = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d = '0;
    ab_d = '0;
    count_d = count_q;
    ptr_d = ptr_q;
    lim_d = lim_q;
    per_d = per_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (valid) begin
        state_d = LOAD;
        grant_d = pick;
        idx_d = pick_idx;
      end
      LOAD: begin
        count_d = '0;
        lim_d = req_limit[int'(idx_q)*CW +: CW];
        per_d = req_per[idx_q];
        state_d = RUN;
      end
      RUN: if (count_q == lim_q) begin
        state_d = DONE;
        done_d = grant_q;
      end else count_d = count_q + 1'b1;
      default: begin
        count_d = '0;
        state_d = (per_q && req[idx_q]) ? RUN : IDLE;
        if (!(per_q && req[idx_q])) begin
          grant_d = '0;
          ptr_d = nxt;
        end
      end
    endcase
`ifdef TIMER_SCHED_ABORT_EN
    // An owner that lets go before terminal count forfeits the slot like a completion.
    if ((state_q == LOAD || state_q == RUN) && !req[idx_q]) begin
      state_d = IDLE;
      grant_d = '0;
      done_d = '0;
      count_d = '0;
      ptr_d = nxt;
      ab_d = grant_q;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q <= '0;
      count_q <= '0;
      ptr_q <= '0;
      lim_q <= '0;
      per_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q <= done_d;
      count_q <= count_d;
      ptr_q <= ptr_d;
      lim_q <= lim_d;
      per_q <= per_d;
      idx_q <= idx_d;
    end
  end
`ifdef TIMER_SCHED_ABORT_EN
  logic [NREQ-1:0] ab_q;
  always_ff @(posedge clk) ab_q <= rst ? '0 : ab_d;
  assign aborted = ab_q;
`else
  logic unused_ab;
  assign unused_ab = ^ab_d;
`endif
  assign grant = grant_q;
  assign done = done_q;
  assign count = count_q;
  assign busy = state_q != IDLE;
endmodule
